crossing_scheduler: RTL

- Right-of-way scheduler in front of the intersection light controller.
- Main road holds green by default. Latched requests are served one at a time in timed phases: country-road car sensor, main-road pedestrian button, country pedestrian button, and emergency vehicle.
- Emits the current phase, a one-hot grant and a seconds countdown. The lamp-driving logic decodes these to drive the lamps.
- Timing advances only on the one-second TICK strobe.

---
 rtl/crossing_pkg.sv | 13 +
 rtl/crossing_scheduler_rr_pick.sv | 46 ++++
 rtl/crossing_scheduler.sv | 128 ++++++++++++
 3 files changed

// File: rtl/crossing_pkg.sv
// Phase encoding shared by crossing_scheduler and the lamp decoder downstream.
package crossing_pkg;

  localparam int PHASE_W = 2;

  typedef enum logic [PHASE_W-1:0] {
    MAIN_GO     = 2'd0,
    MAIN_CLEAR  = 2'd1,
    SERVE       = 2'd2,
    SERVE_CLEAR = 2'd3
  } phase_t;

endpackage

// File: rtl/crossing_scheduler_rr_pick.sv
// Combinational round-robin picker; with ARB_PREEMPT_EN the top requester is an
// absolute-priority emergency input outside the rotation.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] pend,
  input  logic [IW-1:0]    last,
  output logic [N_REQ-1:0] onehot,
  output logic [IW-1:0]    idx,
  output logic             valid
);

`ifdef ARB_PREEMPT_EN
  localparam int RR_N = N_REQ - 1;
`else
  localparam int RR_N = N_REQ;
`endif

  localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

  logic [IW-1:0] idx_s;
  logic          valid_s;
  int            cand_s;

  // Scan farthest-first from last so the nearest pending hit overwrites the rest
  always_comb begin
    idx_s   = '0;
    valid_s = 1'b0;
    cand_s  = 0;
    for (int k = RR_N; k >= 1; k--) begin
      cand_s  = (int'(last) + k) % RR_N;
      valid_s = valid_s | pend[IW'(cand_s)];
      idx_s   = pend[IW'(cand_s)] ? IW'(cand_s) : idx_s;
    end
`ifdef ARB_PREEMPT_EN
    valid_s = valid_s | pend[N_REQ-1];
    idx_s   = pend[N_REQ-1] ? IW'(N_REQ - 1) : idx_s;
`endif
  end

  assign idx    = idx_s;
  assign valid  = valid_s;
  assign onehot = valid_s ? (ONE << idx_s) : '0;

endmodule

// File: rtl/crossing_scheduler.sv
// Right-of-way scheduler: main road green by default, latched requests served in
// timed phases. Optional macro ARB_PREEMPT_EN enables emergency preemption.
module crossing_scheduler
  import crossing_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int MIN_GREEN = 25,
  parameter int CLEAR_T   = 4,
  parameter int SERVE_T   = 16,
  parameter int W         = 5
) (
  input  logic               CLK,
  input  logic               RET,
  input  logic               TICK,
  input  logic [N_REQ-1:0]   REQ,
  output logic [PHASE_W-1:0] PHASE,
  output logic [N_REQ-1:0]   GNT,
  output logic [W-1:0]       T,
  output logic [N_REQ-1:0]   PEND
);

  localparam int IW = $clog2(N_REQ);

  phase_t           phase_r;
  logic [W-1:0]     t_r;
  logic [N_REQ-1:0] gnt_r;
  logic [N_REQ-1:0] pend_r;
  logic [IW-1:0]    last_r;

  logic [N_REQ-1:0] pick_onehot_s;
  logic [IW-1:0]    pick_idx_s;
  logic             pick_valid_s;
  logic [N_REQ-1:0] clr_s;
  logic             tick_dec_s;
  logic             expire_s;
  logic             go_clear_s;

  rr_pick #(.N_REQ(N_REQ), .IW(IW)) u_pick (
    .pend   (pend_r),
    .last   (last_r),
    .onehot (pick_onehot_s),
    .idx    (pick_idx_s),
    .valid  (pick_valid_s)
  );

  // Tick qualification, main-green exit condition and grant-cycle PEND clear
  always_comb begin
    tick_dec_s = TICK && (t_r != '0);
    expire_s   = TICK && (t_r == '0);
    go_clear_s = expire_s && (pend_r != '0);
`ifdef ARB_PREEMPT_EN
    go_clear_s = go_clear_s || pend_r[N_REQ-1];
`endif
    if ((phase_r == MAIN_CLEAR) && expire_s && pick_valid_s) begin
      clr_s = pick_onehot_s;
    end else begin
      clr_s = '0;
    end
  end

  // Phase FSM, countdown, grant, last-served pointer and request latch
  always_ff @(posedge CLK) begin
    if (RET) begin
      phase_r <= MAIN_GO;
      t_r     <= W'(MIN_GREEN);
      gnt_r   <= '0;
      pend_r  <= '0;
      last_r  <= IW'(N_REQ - 2);
    end else begin
      // A new REQ in the grant cycle outranks the clear
      pend_r <= (pend_r & ~clr_s) | REQ;
      if (tick_dec_s) begin
        t_r <= t_r - W'(1);
      end
      case (phase_r)
        MAIN_GO: begin
          if (go_clear_s) begin
            phase_r <= MAIN_CLEAR;
            t_r     <= W'(CLEAR_T);
          end
        end
        MAIN_CLEAR: begin
          if (expire_s) begin
            if (pick_valid_s) begin
              phase_r <= SERVE;
              t_r     <= W'(SERVE_T);
              gnt_r   <= pick_onehot_s;
`ifdef ARB_PREEMPT_EN
              if (pick_idx_s != IW'(N_REQ - 1)) begin
                last_r <= pick_idx_s;
              end
`else
              last_r  <= pick_idx_s;
`endif
            end else begin
              phase_r <= MAIN_GO;
              t_r     <= W'(MIN_GREEN);
            end
          end
        end
        SERVE: begin
          if (expire_s) begin
            phase_r <= SERVE_CLEAR;
            t_r     <= W'(CLEAR_T);
            gnt_r   <= '0;
          end
        end
        SERVE_CLEAR: begin
          if (expire_s) begin
            phase_r <= MAIN_GO;
            t_r     <= W'(MIN_GREEN);
          end
        end
        default: begin
          phase_r <= MAIN_GO;
          t_r     <= W'(MIN_GREEN);
          gnt_r   <= '0;
        end
      endcase
    end
  end

  assign PHASE = phase_r;
  assign GNT   = gnt_r;
  assign T     = t_r;
  assign PEND  = pend_r;

endmodule
